// File: rtl/decoding_cont.sv
`default_nettype none
// ============================================================================
//  Module      : decoding_cont
//  Description : RS(15,9) decoder over GF(16) (x^4+x+1, roots alpha^1..6).
//                Serial syndrome accumulation (15 cycles), one evaluation
//                cycle and one result cycle. Single-symbol correction is
//                built only when macro RS_DEC_CORRECT_EN is defined;
//                otherwise the block is detect-only.
//  Revision    : 1.0  initial release
// ============================================================================
module decoding_cont (
  input  logic        clk,
  input  logic        resetN,
  input  logic [59:0] codeWordVector,
  input  logic        decodeCodeWord,
  output logic        decoderBusy,
  output logic [35:0] decodedMessage,
  output logic        decodeDone,
  output logic        errorCorrected,
  output logic        uncorrectable
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  // alpha^j for j = 1..6, element [j-1]
  localparam logic [5:0][3:0] ALPHA_POW = {4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2};

  // GF(16) multiply, shift-and-add with reduction by x^4+x+1
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  state_t          state_q, state_d;
  logic [59:0]     cw_q, cw_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [5:0][3:0] synd_q, synd_d;
  logic [35:0]     msg_q, msg_d;
  logic            corr_q, corr_d;
  logic            unc_q, unc_d;

  logic [3:0]      sym;
  logic [35:0]     eval_msg;
  logic            eval_corr;
  logic            eval_unc;

  assign sym = cw_q[{cnt_q, 2'b00} +: 4];

`ifdef RS_DEC_CORRECT_EN
  // 16-entry multiplicative inverse table (inverse of 0 defined as 0)
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    case (a)
      4'h1: gf_inv = 4'h1;  4'h2: gf_inv = 4'h9;  4'h3: gf_inv = 4'hE;  4'h4: gf_inv = 4'hD;
      4'h5: gf_inv = 4'hB;  4'h6: gf_inv = 4'h7;  4'h7: gf_inv = 4'h6;  4'h8: gf_inv = 4'hF;
      4'h9: gf_inv = 4'h2;  4'hA: gf_inv = 4'hC;  4'hB: gf_inv = 4'h5;  4'hC: gf_inv = 4'hA;
      4'hD: gf_inv = 4'h4;  4'hE: gf_inv = 4'h3;  4'hF: gf_inv = 4'h8;
      default: gf_inv = 4'h0;
    endcase
  endfunction

  // 16-entry discrete log table (log of 0 defined as 0, never used)
  function automatic logic [3:0] gf_log(input logic [3:0] a);
    case (a)
      4'h1: gf_log = 4'd0;   4'h2: gf_log = 4'd1;   4'h3: gf_log = 4'd4;   4'h4: gf_log = 4'd2;
      4'h5: gf_log = 4'd8;   4'h6: gf_log = 4'd5;   4'h7: gf_log = 4'd10;  4'h8: gf_log = 4'd3;
      4'h9: gf_log = 4'd14;  4'hA: gf_log = 4'd9;   4'hB: gf_log = 4'd7;   4'hC: gf_log = 4'd6;
      4'hD: gf_log = 4'd13;  4'hE: gf_log = 4'd11;  4'hF: gf_log = 4'd12;
      default: gf_log = 4'd0;
    endcase
  endfunction

  logic [3:0]  err_x;
  logic [3:0]  err_y;
  logic [3:0]  err_loc;
  logic [3:0]  loc_in_msg;
  logic        geometric;
  logic        single_err;
  logic [35:0] msg_flip;

  // Single-error test: syndromes must form a geometric series S(j+1)=Sj*X
  always_comb begin
    err_x      = gf_mul(synd_q[1], gf_inv(synd_q[0]));
    err_y      = gf_mul(gf_mul(synd_q[0], synd_q[0]), gf_inv(synd_q[1]));
    err_loc    = gf_log(err_x);
    loc_in_msg = err_loc - 4'd6;
    geometric  = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (synd_q[j+1] != gf_mul(synd_q[j], err_x)) geometric = 1'b0;
    end
    single_err = (synd_q[0] != 4'h0) && (synd_q[1] != 4'h0) && geometric;
    // Parity-symbol errors (loc < 6) leave the message untouched
    msg_flip   = (err_loc >= 4'd6) ? ({32'h0, err_y} << {loc_in_msg, 2'b00}) : 36'h0;
    eval_msg   = cw_q[59:24];
    eval_corr  = 1'b0;
    eval_unc   = 1'b0;
    if (synd_q != '0) begin
      if (single_err) begin
        eval_msg  = cw_q[59:24] ^ msg_flip;
        eval_corr = 1'b1;
      end else begin
        eval_unc  = 1'b1;
      end
    end
  end
`else
  // Detect-only: any nonzero syndrome flags the word, message passes through raw
  always_comb begin
    eval_msg  = cw_q[59:24];
    eval_corr = 1'b0;
    eval_unc  = (synd_q != '0);
  end
`endif

  // Next-state and datapath updates for the IDLE/SYND/EVAL/DONE sequence
  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    cnt_d   = cnt_q;
    synd_d  = synd_q;
    msg_d   = msg_q;
    corr_d  = corr_q;
    unc_d   = unc_q;
    case (state_q)
      IDLE: begin
        if (decodeCodeWord) begin
          cw_d    = codeWordVector;
          synd_d  = '0;
          cnt_d   = 4'd14;
          state_d = SYND;
        end
      end
      SYND: begin
        // Horner step, highest symbol first
        for (int j = 0; j < 6; j++) begin
          synd_d[j] = gf_mul(synd_q[j], ALPHA_POW[j]) ^ sym;
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = EVAL;
      end
      EVAL: begin
        msg_d   = eval_msg;
        corr_d  = eval_corr;
        unc_d   = eval_unc;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      cw_q    <= '0;
      cnt_q   <= '0;
      synd_q  <= '0;
      msg_q   <= '0;
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      cnt_q   <= cnt_d;
      synd_q  <= synd_d;
      msg_q   <= msg_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
    end
  end

  assign decoderBusy    = (state_q != IDLE);
  assign decodeDone     = (state_q == DONE);
  assign decodedMessage = msg_q;
  assign errorCorrected = corr_q;
  assign uncorrectable  = unc_q;

endmodule
`default_nettype wire

// File: tb/tb_decoding_cont.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoding_cont
//  Description : Scoreboard bench for decoding_cont. Reference model works
//                from the code definition: syndromes by direct evaluation
//                and a brute-force search over all single-symbol errors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoding_cont;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [59:0] codeWordVector = '0;
  logic        decodeCodeWord = 1'b0;
  logic        decoderBusy;
  logic [35:0] decodedMessage;
  logic        decodeDone;
  logic        errorCorrected;
  logic        uncorrectable;

  decoding_cont dut (
    .clk            (clk),
    .resetN         (resetN),
    .codeWordVector (codeWordVector),
    .decodeCodeWord (decodeCodeWord),
    .decoderBusy    (decoderBusy),
    .decodedMessage (decodedMessage),
    .decodeDone     (decodeDone),
    .errorCorrected (errorCorrected),
    .uncorrectable  (uncorrectable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [35:0] msg;
    logic        corr;
    logic        unc;
    int          done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  int tb_exp[0:14];
  int tb_log[0:15];
  int gen[0:6];

  function automatic int gm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return tb_exp[(tb_log[a] + tb_log[b]) % 15];
  endfunction

  function automatic int gpow(input int k);
    return tb_exp[k % 15];
  endfunction

  // Codeword as polynomial product m(x)*g(x)
  function automatic logic [59:0] encode(input logic [35:0] m);
    logic [59:0] c;
    int s;
    c = '0;
    for (int i = 0; i < 15; i++) begin
      s = 0;
      for (int k = 0; k < 9; k++) begin
        if (i - k >= 0 && i - k <= 6) s = s ^ gm(int'(m[4*k +: 4]), gen[i-k]);
      end
      c[4*i +: 4] = 4'(s);
    end
    return c;
  endfunction

  function automatic exp_t model(input logic [59:0] w);
    exp_t r;
    int   syn[1:6];
    bit   nz;
    bit   found;
    bit   ok;
    logic [59:0] fixed;
    r.msg = w[59:24]; r.corr = 1'b0; r.unc = 1'b0; r.done_cyc = 0;
    nz = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      syn[j] = 0;
      for (int i = 0; i < 15; i++) syn[j] = syn[j] ^ gm(int'(w[4*i +: 4]), gpow(i*j));
      if (syn[j] != 0) nz = 1'b1;
    end
    if (nz) begin
      found = 1'b0;
      fixed = w;
`ifdef RS_DEC_CORRECT_EN
      for (int l = 0; l < 15; l++) begin
        for (int e = 1; e < 16; e++) begin
          ok = 1'b1;
          for (int j = 1; j <= 6; j++) if (syn[j] != gm(e, gpow(l*j))) ok = 1'b0;
          if (ok && !found) begin
            found = 1'b1;
            fixed[4*l +: 4] = w[4*l +: 4] ^ 4'(e);
          end
        end
      end
`else
      ok = 1'b0;
`endif
      if (found) begin
        r.msg  = fixed[59:24];
        r.corr = 1'b1;
      end else begin
        r.unc  = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever the DUT signals completion
  exp_t me;
  always @(negedge clk) begin
    if (resetN && decodeDone) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: decodeDone=1 at cycle %0d, expected none", cyc);
      end else begin
        me = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(me.done_cyc));
        chk("message", 64'(decodedMessage), 64'(me.msg));
        chk("error_corrected", 64'(errorCorrected), 64'(me.corr));
        chk("uncorrectable", 64'(uncorrectable), 64'(me.unc));
        chk("flags_exclusive", 64'(errorCorrected & uncorrectable), 64'd0);
      end
    end
  end

  task automatic wait_empty();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: %0d results pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run_decode(input logic [59:0] word);
    exp_t e;
    @(negedge clk);
    codeWordVector = word;
    decodeCodeWord = 1'b1;
    @(posedge clk);
    #1;
    decodeCodeWord = 1'b0;
    e = model(word);
    e.done_cyc = cyc + 16;
    sbq.push_back(e);
    codeWordVector = {$urandom(), $urandom()};
    chk("busy_after_start", 64'(decoderBusy), 64'd1);
    wait_empty();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(decoderBusy), 64'd0);
    chk({tag, "_done"}, 64'(decodeDone), 64'd0);
    chk({tag, "_msg"}, 64'(decodedMessage), 64'd0);
    chk({tag, "_corr"}, 64'(errorCorrected), 64'd0);
    chk({tag, "_unc"}, 64'(uncorrectable), 64'd0);
  endtask

  function automatic logic [59:0] rand_word(input int nerr);
    logic [59:0] w;
    int pos;
    w = encode(36'({$urandom(), $urandom()}));
    for (int k = 0; k < nerr; k++) begin
      pos = $urandom_range(0, 14);
      w[4*pos +: 4] = w[4*pos +: 4] ^ 4'($urandom_range(1, 15));
    end
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    exp_t ea;
    exp_t eb;
    logic [59:0] wa;
    logic [59:0] wb;

    // Field and generator tables
    v = 1;
    tb_log[0] = 0;
    for (int k = 0; k < 15; k++) begin
      tb_exp[k] = v;
      tb_log[v] = k;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 'h13;
    end
    for (int i = 0; i <= 6; i++) gen[i] = 0;
    gen[0] = 1;
    for (int j = 1; j <= 6; j++) begin
      for (int i = j; i >= 0; i--) gen[i] = ((i > 0) ? gen[i-1] : 0) ^ gm(gen[i], gpow(j));
    end

    // Reset state
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    resetN = 1'b1;

    // Directed cases
    run_decode(60'h0);
    run_decode(60'h3 << 40);
    run_decode(60'h5 << 8);
    run_decode((60'h3 << 40) | (60'h9 << 48));
    chk("two_err_pattern_msg", 64'(decodedMessage), 64'h009030000);

    // Randomized codewords with 0..3 symbol errors
    for (int n = 0; n < 60; n++) begin
      run_decode(rand_word($urandom_range(0, 3)));
    end
    // Make sure the abort check below starts from nonzero outputs
    run_decode(rand_word(2) | (60'h1 << 56));

    // Reset in SYND cycle 8 aborts the decode
    @(negedge clk);
    codeWordVector = rand_word(1);
    decodeCodeWord = 1'b1;
    @(posedge clk);
    #1;
    decodeCodeWord = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    repeat (25) @(negedge clk);
    run_decode(rand_word(1));

    // Request held high: two back-to-back decodes, inputs changing mid-decode
    wa = rand_word(1);
    wb = rand_word(2);
    @(negedge clk);
    codeWordVector = wa;
    decodeCodeWord = 1'b1;
    @(posedge clk);
    #1;
    ea = model(wa);
    ea.done_cyc = cyc + 16;
    sbq.push_back(ea);
    codeWordVector = wb;
    repeat (17) @(posedge clk);
    #1;
    chk("b2b_idle_busy", 64'(decoderBusy), 64'd0);
    @(posedge clk);
    #1;
    eb = model(wb);
    eb.done_cyc = cyc + 16;
    sbq.push_back(eb);
    decodeCodeWord = 1'b0;
    codeWordVector = {$urandom(), $urandom()};
    wait_empty();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
